// File: rtl/nodeset_pkg.sv
// Shared types and helpers for the nodeset request fabric: tag widths,
// global phase encoding and tag field extraction.
package nodeset_pkg;

   localparam int NODE_TAG_W  = 12;
   localparam int LOCAL_TAG_W = 6;
   localparam int SET_IDX_W   = NODE_TAG_W - LOCAL_TAG_W;

   typedef enum logic [1:0] {
      PH_LOAD  = 2'd0,
      PH_MARK  = 2'd1,
      PH_COUNT = 2'd2,
      PH_DONE  = 2'd3
   } phase_e;

   function automatic logic [SET_IDX_W-1:0] set_idx(input logic [NODE_TAG_W-1:0] tag);
      return tag[NODE_TAG_W-1:LOCAL_TAG_W];
   endfunction

   function automatic logic [LOCAL_TAG_W-1:0] local_tag(input logic [NODE_TAG_W-1:0] tag);
      return tag[LOCAL_TAG_W-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo N. Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   localparam logic [IW:0] N_W = (IW+1)'(N);

   logic          found_s;
   logic [IW:0]   pos_s;

   // Scan N positions starting at ptr and keep the first active requester.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found_s = 1'b0;
      pos_s   = '0;
      for (int i = 0; i < N; i++) begin
         pos_s = {1'b0, ptr} + (IW+1)'(i);
         if (pos_s >= N_W) begin
            pos_s = pos_s - N_W;
         end else begin
            pos_s = pos_s;
         end
         if (!found_s && req[pos_s[IW-1:0]]) begin
            gnt[pos_s[IW-1:0]] = 1'b1;
            gnt_idx            = pos_s[IW-1:0];
            found_s            = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/nodeset_req_router.sv
// Inter-nodeset request router with per-destination round-robin arbitration
// and the global load/mark/count/done phase sequencer. Optional ROUTER_STATS_EN.
module nodeset_req_router
   import nodeset_pkg::*;
#(
   parameter int NUM_SETS     = 8,
   parameter int NUM_PATHS_DW = 16,
   parameter int QUIET_CYCLES = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_SETS-1:0]              i_src_vld,
   input  logic [NUM_SETS*NODE_TAG_W-1:0]   i_src_nodenum,
   input  logic [NUM_SETS*NUM_PATHS_DW-1:0] i_src_paths,
   output logic [NUM_SETS-1:0]              o_src_ack,
   output logic [NUM_SETS-1:0]              o_dst_vld,
   output logic [NUM_SETS*LOCAL_TAG_W-1:0]  o_dst_nodenum,
   output logic [NUM_SETS*NUM_PATHS_DW-1:0] o_dst_paths,
   input  logic [NUM_SETS-1:0]              i_reqs_complete,
   input  logic                             i_list_done,
   output logic                             o_start_counting,
   output logic                             o_done
`ifdef ROUTER_STATS_EN
   ,
   output logic [31:0]                      o_grant_cnt,
   output logic [31:0]                      o_stall_cnt,
   output logic                             o_bad_dst
`endif
);

   localparam int SEL_W = $clog2(NUM_SETS);
   localparam int QW    = $clog2(QUIET_CYCLES + 1);
   localparam int BW    = $clog2(QUIET_CYCLES + 3);
   localparam logic [QW-1:0]    QUIET_MAX = QW'(QUIET_CYCLES);
   localparam logic [BW-1:0]    BLANK_MAX = BW'(QUIET_CYCLES + 2);
   localparam logic [SEL_W-1:0] LAST_SET  = SEL_W'(NUM_SETS - 1);

   logic [NODE_TAG_W-1:0]   src_tag_s   [NUM_SETS];
   logic [NUM_PATHS_DW-1:0] src_paths_s [NUM_SETS];
   logic [NUM_SETS-1:0]     req_s       [NUM_SETS];
   logic [NUM_SETS-1:0]     gnt_s       [NUM_SETS];
   logic [SEL_W-1:0]        gnt_idx_s   [NUM_SETS];
   logic [SEL_W-1:0]        ptr_r       [NUM_SETS];
   logic [LOCAL_TAG_W-1:0]  dst_tag_r   [NUM_SETS];
   logic [NUM_PATHS_DW-1:0] dst_paths_r [NUM_SETS];
   logic [NUM_SETS-1:0]     dst_vld_r;
   logic [NUM_SETS-1:0]     ack_s;
   logic                    busy_s;
   phase_e                  phase_r;
   logic [QW-1:0]           quiet_r;
   logic [BW-1:0]           blank_r;
   logic                    start_r;
   logic                    done_r;

   genvar g;
   generate
      for (g = 0; g < NUM_SETS; g++) begin : g_lane
         assign src_tag_s[g]   = i_src_nodenum[g*NODE_TAG_W +: NODE_TAG_W];
         assign src_paths_s[g] = i_src_paths[g*NUM_PATHS_DW +: NUM_PATHS_DW];
         assign o_dst_nodenum[g*LOCAL_TAG_W +: LOCAL_TAG_W]   = dst_tag_r[g];
         assign o_dst_paths[g*NUM_PATHS_DW +: NUM_PATHS_DW]   = dst_paths_r[g];

         rr_arbiter #(.N(NUM_SETS), .IW(SEL_W)) u_arb (
            .req     (req_s[g]),
            .ptr     (ptr_r[g]),
            .gnt     (gnt_s[g]),
            .gnt_idx (gnt_idx_s[g])
         );
      end
   endgenerate

   // Request matrix: req_s[d][s] when source s is valid and its tag selects d.
   always_comb begin
      for (int d = 0; d < NUM_SETS; d++) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            req_s[d][s] = i_src_vld[s] && (set_idx(src_tag_s[s]) == SET_IDX_W'(d));
         end
      end
   end

   // A source targets a single destination, so OR-ing all grants gives its ack.
   always_comb begin
      ack_s = '0;
      for (int d = 0; d < NUM_SETS; d++) begin
         ack_s = ack_s | gnt_s[d];
      end
   end

   assign o_src_ack = rst ? '0 : ack_s;
   assign busy_s    = (|i_src_vld) | (|dst_vld_r) | ~(&i_reqs_complete);

   // Register each destination's granted request for one cycle; advance its pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         dst_vld_r <= '0;
         for (int d = 0; d < NUM_SETS; d++) begin
            ptr_r[d]       <= '0;
            dst_tag_r[d]   <= '0;
            dst_paths_r[d] <= '0;
         end
      end else begin
         for (int d = 0; d < NUM_SETS; d++) begin
            if (|gnt_s[d]) begin
               dst_vld_r[d]   <= 1'b1;
               dst_tag_r[d]   <= local_tag(src_tag_s[gnt_idx_s[d]]);
               dst_paths_r[d] <= src_paths_s[gnt_idx_s[d]];
               ptr_r[d]       <= (gnt_idx_s[d] == LAST_SET) ? '0 : gnt_idx_s[d] + SEL_W'(1);
            end else begin
               dst_vld_r[d] <= 1'b0;
            end
         end
      end
   end

   // Phase sequencer with quiescence counter and post-start blanking window.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_r <= PH_LOAD;
         quiet_r <= '0;
         blank_r <= '0;
         start_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         if (busy_s) begin
            quiet_r <= '0;
         end else if (quiet_r != QUIET_MAX) begin
            quiet_r <= quiet_r + QW'(1);
         end else begin
            quiet_r <= quiet_r;
         end
         case (phase_r)
            PH_LOAD: begin
               if (i_list_done) begin
                  phase_r <= PH_MARK;
                  quiet_r <= '0;
               end
            end
            PH_MARK: begin
               if (quiet_r == QUIET_MAX) begin
                  phase_r <= PH_COUNT;
                  start_r <= 1'b1;
                  quiet_r <= '0;
                  blank_r <= '0;
               end
            end
            PH_COUNT: begin
               start_r <= 1'b1;
               // Nodesets need a few cycles to react to start before idle means done.
               if (blank_r != BLANK_MAX) begin
                  blank_r <= blank_r + BW'(1);
               end else if (quiet_r == QUIET_MAX) begin
                  phase_r <= PH_DONE;
                  done_r  <= 1'b1;
               end
            end
            PH_DONE: begin
               start_r <= 1'b1;
               done_r  <= 1'b1;
            end
            default: begin
               phase_r <= PH_LOAD;
            end
         endcase
      end
   end

   assign o_dst_vld        = dst_vld_r;
   assign o_start_counting = start_r;
   assign o_done           = done_r;

`ifdef ROUTER_STATS_EN
   logic [31:0] grant_cnt_r;
   logic [31:0] stall_cnt_r;
   logic        bad_dst_r;
   logic        bad_s;

   // Flag any valid source whose set index names a nonexistent nodeset.
   always_comb begin
      bad_s = 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
         if (i_src_vld[s] && ({1'b0, set_idx(src_tag_s[s])} >= (SET_IDX_W+1)'(NUM_SETS))) begin
            bad_s = 1'b1;
         end else begin
            bad_s = bad_s;
         end
      end
   end

   // Wrapping grant/stall counters and sticky bad-destination flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_r <= 32'd0;
         stall_cnt_r <= 32'd0;
         bad_dst_r   <= 1'b0;
      end else begin
         grant_cnt_r <= grant_cnt_r + 32'($countones(ack_s));
         stall_cnt_r <= stall_cnt_r + 32'($countones(i_src_vld & ~ack_s));
         bad_dst_r   <= bad_dst_r | bad_s;
      end
   end

   assign o_grant_cnt = grant_cnt_r;
   assign o_stall_cnt = stall_cnt_r;
   assign o_bad_dst   = bad_dst_r;
`endif

endmodule

// File: tb/tb_nodeset_req_router.sv
// Directed bench for nodeset_req_router (NUM_SETS=8, 16-bit paths, QUIET_CYCLES=4):
// routing, round-robin order, parallel grants, phase sequencing and reset.
module tb_nodeset_req_router;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    src_vld;
   logic [95:0]   src_nodenum;
   logic [127:0]  src_paths;
   logic [7:0]    ack;
   logic [7:0]    dst_vld;
   logic [47:0]   dst_nodenum;
   logic [127:0]  dst_paths;
   logic [7:0]    reqs_complete;
   logic          list_done;
   logic          start_counting;
   logic          done;
`ifdef ROUTER_STATS_EN
   logic [31:0]   grant_cnt;
   logic [31:0]   stall_cnt;
   logic          bad_dst;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   nodeset_req_router #(.NUM_SETS(8), .NUM_PATHS_DW(16), .QUIET_CYCLES(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_src_vld        (src_vld),
      .i_src_nodenum    (src_nodenum),
      .i_src_paths      (src_paths),
      .o_src_ack        (ack),
      .o_dst_vld        (dst_vld),
      .o_dst_nodenum    (dst_nodenum),
      .o_dst_paths      (dst_paths),
      .i_reqs_complete  (reqs_complete),
      .i_list_done      (list_done),
      .o_start_counting (start_counting),
      .o_done           (done)
`ifdef ROUTER_STATS_EN
      ,
      .o_grant_cnt      (grant_cnt),
      .o_stall_cnt      (stall_cnt),
      .o_bad_dst        (bad_dst)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int s, input logic [11:0] tag, input logic [15:0] p);
      src_vld[s]            = 1'b1;
      src_nodenum[s*12 +: 12] = tag;
      src_paths[s*16 +: 16]   = p;
   endtask

   logic [7:0]  rr_ack   [4] = '{8'h01, 8'h08, 8'h20, 8'h01};
   logic [5:0]  rr_tag   [4] = '{6'h01, 6'h02, 6'h03, 6'h01};
   logic [15:0] rr_paths [4] = '{16'h0010, 16'h0030, 16'h0050, 16'h0010};
   logic [11:0] burst_tag;

   initial begin
      rst = 1'b1; src_vld = '0; src_nodenum = '0; src_paths = '0;
      reqs_complete = 8'hFF; list_done = 1'b0;
      tick(); tick();
      check("rst_dst_vld", dst_vld, 8'h00);
      check("rst_start", start_counting, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ack", ack, 8'h00);
      rst = 1'b0;

      // Single request: src2, tag 0x1C5 -> set 7, local 0x05.
      set_src(2, 12'h1C5, 16'hBEEF); #1;
      check("single_ack", ack, 8'h04);
      tick(); src_vld = '0;
      check("single_dst_vld", dst_vld, 8'h80);
      check("single_tag", dst_nodenum[42 +: 6], 6'h05);
      check("single_paths", dst_paths[112 +: 16], 16'hBEEF);
      tick();
      check("single_one_cycle", dst_vld, 8'h00);

      // Sources 0, 3, 5 contend for set 1: expect 0, 3, 5, 0.
      set_src(0, 12'h041, 16'h0010); set_src(3, 12'h042, 16'h0030); set_src(5, 12'h043, 16'h0050); #1;
      for (int i = 0; i < 4; i++) begin
         check("rr_ack", ack, rr_ack[i]);
         tick();
         check("rr_dst_vld", dst_vld, 8'h02);
         check("rr_tag", dst_nodenum[6 +: 6], rr_tag[i]);
         check("rr_paths", dst_paths[16 +: 16], rr_paths[i]);
      end
      // Pointer is now 1, so source 1 beats source 0.
      src_vld = '0;
      set_src(0, 12'h044, 16'h0044); set_src(1, 12'h045, 16'h0011); #1;
      check("rr_ptr_after_wrap", ack, 8'h02);
      tick(); src_vld = '0;
      check("rr_ptr_tag", dst_nodenum[6 +: 6], 6'h05);

      // Parallel grants to sets 2 and 4; source 3 names set 63 and is never acked.
      set_src(0, 12'h08A, 16'h00A0); set_src(1, 12'h10B, 16'h00B0); set_src(3, 12'hFC0, 16'h0003); #1;
      check("par_ack", ack, 8'h03);
      tick();
      check("par_dst_vld", dst_vld, 8'h14);
      check("par_tag2", dst_nodenum[12 +: 6], 6'h0A);
      check("par_tag4", dst_nodenum[24 +: 6], 6'h0B);
      src_vld = 8'h08; #1;
      check("bad_dst_no_ack", ack, 8'h00);
      tick();
      check("bad_dst_no_ack2", ack, 8'h00);
      check("bad_dst_no_vld", dst_vld, 8'h00);
      src_vld = '0;
      tick();

      // Idle list_done pulse: start rises QUIET_CYCLES+1 edges later.
      list_done = 1'b1; tick(); list_done = 1'b0;
      check("mark_entry_start", start_counting, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("mark_wait", start_counting, 1'b0);
      end
      tick();
      check("mark_start", start_counting, 1'b1);
      check("mark_no_done", done, 1'b0);

      rst = 1'b1; tick(); rst = 1'b0;
      check("reset_clears_start", start_counting, 1'b0);

      // reqs_complete glitch at quiet=3 restarts the count: start at L+9.
      list_done = 1'b1; tick(); list_done = 1'b0;
      tick(); tick(); tick();
      reqs_complete = 8'hFE; tick(); reqs_complete = 8'hFF;
      for (int k = 5; k <= 8; k++) begin
         tick();
         check("restart_wait", start_counting, 1'b0);
      end
      tick();
      check("restart_start", start_counting, 1'b1);

      // Counting phase: 10-cycle burst into set 3, then idle until done.
      for (int i = 0; i < 10; i++) begin
         burst_tag = 12'h0C0 + 12'(i);
         set_src(0, burst_tag, 16'(i));
         tick();
         check("burst_vld", dst_vld, 8'h08);
         check("burst_tag", dst_nodenum[18 +: 6], 6'(i));
      end
      src_vld = '0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("done_wait", done, 1'b0);
      end
      tick();
      check("done_rise", done, 1'b1);
      check("done_start_held", start_counting, 1'b1);

      // Reset mid-transfer clears outputs and pointers.
      set_src(0, 12'h140, 16'h1111); set_src(2, 12'h141, 16'h2222); #1;
      check("mid_ack0", ack, 8'h01);
      tick();
      check("mid_dst_vld", dst_vld, 8'h20);
      check("mid_ack2", ack, 8'h04);
      rst = 1'b1; #1;
      check("mid_rst_ack", ack, 8'h00);
      tick();
      check("mid_rst_dst_vld", dst_vld, 8'h00);
      check("mid_rst_done", done, 1'b0);
      check("mid_rst_start", start_counting, 1'b0);
      rst = 1'b0; #1;
      check("mid_rst_ptr", ack, 8'h01);
      tick(); src_vld = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
